l2c_port_arb: RTL
=================

Name: l2c_port_arb

Overview:
- Two-port arbiter sharing the single L2C request/response interface between the data L1 (port 0, DL1) and the instruction L1 (port 1, IL1).
- Grants one requester at a time and holds that grant for the whole transaction, including multi-beat line fills.
- Routes rdata, rdata_valid and tlb_fault only to the owner; every other requester sees stall.
- Sits between the L1 blocks and L2C; invalidation traffic bypasses it.

Parameters:
- RESET_LAST, 1, value loaded into the last-grant pointer at reset (1 gives DL1 first priority).

Ports:
- clk_mc  in  1  core clock.
- rst_mc_n  in  1  asynchronous active-low reset.
- i_ctl_fixed_prio  in  1  1 = DL1 always wins ties; 0 = round-robin.
- o_ctl_busy  out  1  a grant is held.
- i_dl1_adr/i_il1_adr  in  32  request address.
- i_dl1_flags/i_il1_flags  in  2  request flags.
- i_dl1_ben/i_il1_ben  in  4  byte enables.
- i_dl1_wen/i_il1_wen  in  1  write.
- i_dl1_wdata/i_il1_wdata  in  32  write data.
- i_dl1_valid/i_il1_valid  in  1  request valid, held until completion.
- o_dl1_rdata/o_il1_rdata  out  32  read data.
- o_dl1_rdata_valid/o_il1_rdata_valid  out  1  read beat strobe.
- o_dl1_tlb_fault/o_il1_tlb_fault  out  1  fault.
- o_dl1_stall/o_il1_stall  out  1  request not complete.
- o_l2c_adr  out  32  request address to L2C.
- o_l2c_flags  out  2  request flags to L2C.
- o_l2c_ben  out  4  byte enables to L2C.
- o_l2c_wen  out  1  write to L2C.
- o_l2c_wdata  out  32  write data to L2C.
- o_l2c_valid  out  1  request valid to L2C.
- i_l2c_rdata  in  32  read data from L2C.
- i_l2c_rdata_valid  in  1  read beat strobe from L2C.
- i_l2c_tlb_fault  in  1  fault from L2C.
- i_l2c_stall  in  1  L2C transaction incomplete.

Behaviour:
- FSM states: IDLE, GNT0 (DL1 owns), GNT1 (IL1 owns). Grant is a registered state; the L2C-side mux is combinational from the state.
- Reset (async, rst_mc_n=0):
  - State = IDLE, last = RESET_LAST.
  - o_l2c_valid = 0, o_ctl_busy = 0.
  - Both o_*_stall = 1, both o_*_rdata_valid = 0, both o_*_tlb_fault = 0.
  - o_l2c_adr/flags/ben/wen/wdata = 0.
  - Reset mid-transaction abandons the grant; no beats are forwarded after reset assertion.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: fixed_prio=1 picks DL1; otherwise pick the port != last.
  - Grant takes effect next cycle, so there is one cycle of arbitration latency from requester valid to o_l2c_valid.
- In GNTp:
  - o_l2c_{adr,flags,ben,wen,wdata} = port p fields.
  - o_l2c_valid = i_p_valid.
  - o_p_stall = i_l2c_stall & ~i_l2c_tlb_fault.
  - o_p_rdata = i_l2c_rdata; o_p_rdata_valid = i_l2c_rdata_valid; o_p_tlb_fault = i_l2c_tlb_fault.
  - The non-owner gets stall = 1, rdata_valid = 0, tlb_fault = 0, and rdata = i_l2c_rdata (don't care).
- Completion in GNTp: i_p_valid & (~i_l2c_stall | i_l2c_tlb_fault).
  - last <= p.
  - Next state: if the other port is valid, GNT(other) (back-to-back, no IDLE bubble). Else IDLE.
  - The owner's own re-request next cycle must re-arbitrate from IDLE.
- Abort: in GNTp with i_p_valid = 0, return to IDLE next cycle, last unchanged, nothing forwarded to L2C.
- Beats with i_l2c_rdata_valid = 1 in IDLE are dropped: both rdata_valid outputs stay 0.
- A beat and completion in the same cycle is forwarded to the owner in that cycle.
- In IDLE, all L2C outputs except valid hold their last values; o_l2c_valid = 0.
- o_ctl_busy = (state != IDLE).
- In fixed-priority mode IL1 can starve. This is accepted and is software's choice.

Test Plan:
- DL1-only read:
  - Stimulus: i_dl1_valid rises at cycle 0, adr 0x0000_1040, flags 2'b10; L2C holds stall for 8 cycles while sending 8 rdata_valid beats, then stall = 0.
  - Required: o_l2c_valid = 1 from cycle 1, adr 0x0000_1040; 8 beats appear on o_dl1_rdata_valid; o_il1_rdata_valid stays 0; FSM returns to IDLE.
- Simultaneous requests, round-robin:
  - Stimulus: both valid at cycle 0, last = 1 after reset.
  - Required: DL1 granted first; after DL1 completes, GNT1 next cycle with no IDLE, o_l2c_adr = IL1 adr; o_il1_stall = 1 throughout the DL1 transaction.
- Fixed priority:
  - Stimulus: i_ctl_fixed_prio = 1, both valid continuously for 3 transactions.
  - Required: DL1 wins every IDLE arbitration.
  - Stimulus: same, but DL1 drops valid after its first completion.
  - Required: IL1 is granted back-to-back.
- TLB fault:
  - Stimulus: in GNT1, i_l2c_tlb_fault = 1 while i_l2c_stall = 1.
  - Required: o_il1_tlb_fault = 1 and o_il1_stall = 0 in the same cycle; state leaves GNT1 next cycle; o_dl1_tlb_fault stays 0.
- Write completion:
  - Stimulus: DL1 write, ben 4'b0011, wdata 0xDEADBEEF; stall = 1 for 2 cycles, then 0.
  - Required: o_l2c_wen = 1, o_l2c_ben = 4'b0011, o_l2c_wdata = 0xDEADBEEF held for 3 cycles; o_dl1_stall falls in the 3rd cycle.
- Reset mid-fill:
  - Stimulus: assert rst_mc_n = 0 after beat 3 of 8, asynchronously to clk_mc.
  - Required: o_l2c_valid = 0 and o_ctl_busy = 0 immediately; no further o_dl1_rdata_valid; after release, first arbitration grants DL1.

Source files
------------

// File: rtl/l2c_port_arb.sv
// l2c_port_arb: shares the single L2C request/response interface between
// the data L1 (port 0) and the instruction L1 (port 1). One owner at a time,
// held for the whole transaction including multi-beat line fills.
module l2c_port_arb #(
    parameter bit RESET_LAST = 1'b1  // 1: last grant was IL1, so DL1 wins first
) (
    input  logic        clk_mc,
    input  logic        rst_mc_n,

    input  logic        i_ctl_fixed_prio,
    output logic        o_ctl_busy,

    input  logic [31:0] i_dl1_adr,
    input  logic [1:0]  i_dl1_flags,
    input  logic [3:0]  i_dl1_ben,
    input  logic        i_dl1_wen,
    input  logic [31:0] i_dl1_wdata,
    input  logic        i_dl1_valid,
    output logic [31:0] o_dl1_rdata,
    output logic        o_dl1_rdata_valid,
    output logic        o_dl1_tlb_fault,
    output logic        o_dl1_stall,

    input  logic [31:0] i_il1_adr,
    input  logic [1:0]  i_il1_flags,
    input  logic [3:0]  i_il1_ben,
    input  logic        i_il1_wen,
    input  logic [31:0] i_il1_wdata,
    input  logic        i_il1_valid,
    output logic [31:0] o_il1_rdata,
    output logic        o_il1_rdata_valid,
    output logic        o_il1_tlb_fault,
    output logic        o_il1_stall,

    output logic [31:0] o_l2c_adr,
    output logic [1:0]  o_l2c_flags,
    output logic [3:0]  o_l2c_ben,
    output logic        o_l2c_wen,
    output logic [31:0] o_l2c_wdata,
    output logic        o_l2c_valid,
    input  logic [31:0] i_l2c_rdata,
    input  logic        i_l2c_rdata_valid,
    input  logic        i_l2c_tlb_fault,
    input  logic        i_l2c_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;      // port that completed most recently
    logic        w_last_nxt;

    // Held copies of the request fields so L2C sees stable values in IDLE
    logic [31:0] r_adr;
    logic [1:0]  r_flags;
    logic [3:0]  r_ben;
    logic        r_wen;
    logic [31:0] r_wdata;

    logic [31:0] w_adr;
    logic [1:0]  w_flags;
    logic [3:0]  w_ben;
    logic        w_wen;
    logic [31:0] w_wdata;
    logic        w_valid;

    // A fault ends the transaction even while L2C still reports stall
    logic        w_l2c_done;
    logic        w_done0;
    logic        w_done1;

    assign w_l2c_done = ~i_l2c_stall | i_l2c_tlb_fault;
    assign w_done0    = i_dl1_valid & w_l2c_done;
    assign w_done1    = i_il1_valid & w_l2c_done;

    // State and last-grant pointer
    always_ff @(posedge clk_mc or negedge rst_mc_n) begin
        if (!rst_mc_n) begin
            r_state <= IDLE;
            r_last  <= RESET_LAST;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Arbitration and completion: next state and next last-grant pointer
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (i_dl1_valid && i_il1_valid) begin
                    if (i_ctl_fixed_prio || r_last) w_state_nxt = GNT0;
                    else                            w_state_nxt = GNT1;
                end else if (i_dl1_valid) begin
                    w_state_nxt = GNT0;
                end else if (i_il1_valid) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!i_dl1_valid) begin
                    // Abort: requester withdrew, pointer untouched
                    w_state_nxt = IDLE;
                end else if (w_done0) begin
                    w_last_nxt  = 1'b0;
                    // Hand straight over to a waiting IL1; DL1 must re-arbitrate
                    w_state_nxt = i_il1_valid ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!i_il1_valid) begin
                    w_state_nxt = IDLE;
                end else if (w_done1) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = i_dl1_valid ? GNT0 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // L2C request mux driven by the owner; IDLE replays the held fields
    always_comb begin
        w_adr   = r_adr;
        w_flags = r_flags;
        w_ben   = r_ben;
        w_wen   = r_wen;
        w_wdata = r_wdata;
        w_valid = 1'b0;
        case (r_state)
            GNT0: begin
                w_adr   = i_dl1_adr;
                w_flags = i_dl1_flags;
                w_ben   = i_dl1_ben;
                w_wen   = i_dl1_wen;
                w_wdata = i_dl1_wdata;
                w_valid = i_dl1_valid;
            end
            GNT1: begin
                w_adr   = i_il1_adr;
                w_flags = i_il1_flags;
                w_ben   = i_il1_ben;
                w_wen   = i_il1_wen;
                w_wdata = i_il1_wdata;
                w_valid = i_il1_valid;
            end
            default: ;
        endcase
    end

    // Capture whatever the owner presents so it can be replayed once idle
    always_ff @(posedge clk_mc or negedge rst_mc_n) begin
        if (!rst_mc_n) begin
            r_adr   <= '0;
            r_flags <= '0;
            r_ben   <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else if (r_state != IDLE) begin
            r_adr   <= w_adr;
            r_flags <= w_flags;
            r_ben   <= w_ben;
            r_wen   <= w_wen;
            r_wdata <= w_wdata;
        end
    end

    assign o_l2c_adr   = w_adr;
    assign o_l2c_flags = w_flags;
    assign o_l2c_ben   = w_ben;
    assign o_l2c_wen   = w_wen;
    assign o_l2c_wdata = w_wdata;
    assign o_l2c_valid = w_valid;
    assign o_ctl_busy  = (r_state != IDLE);

    // Response routing: only the owner sees beats/faults; everyone else stalls
    always_comb begin
        o_dl1_stall       = 1'b1;
        o_dl1_rdata_valid = 1'b0;
        o_dl1_tlb_fault   = 1'b0;
        o_il1_stall       = 1'b1;
        o_il1_rdata_valid = 1'b0;
        o_il1_tlb_fault   = 1'b0;
        case (r_state)
            GNT0: begin
                o_dl1_stall       = i_l2c_stall & ~i_l2c_tlb_fault;
                o_dl1_rdata_valid = i_l2c_rdata_valid;
                o_dl1_tlb_fault   = i_l2c_tlb_fault;
            end
            GNT1: begin
                o_il1_stall       = i_l2c_stall & ~i_l2c_tlb_fault;
                o_il1_rdata_valid = i_l2c_rdata_valid;
                o_il1_tlb_fault   = i_l2c_tlb_fault;
            end
            default: ;
        endcase
    end

    // Read data is shared; the per-port strobes qualify it
    assign o_dl1_rdata = i_l2c_rdata;
    assign o_il1_rdata = i_l2c_rdata;

endmodule
